// File: rtl/utf8_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : utf8_stream_decoder
//  Brief    : Streaming UTF-8 to code-point decoder. Takes one byte per cycle
//             on a valid/ready input. Decoded scalars and error tokens go
//             into an output FIFO that a valid/ready consumer drains.
//  Revision : 1.0 - initial release
// ============================================================================
module utf8_stream_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int STRICT     = 1,
    parameter int REPLACE    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [20:0]                   out_cp,
    output logic                          out_err,
    output logic [2:0]                    out_len,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int               AW      = $clog2(FIFO_DEPTH);
    localparam int               CW      = AW + 1;
    localparam logic [20:0]      C_REPL  = 21'h00FFFD;
    localparam logic [20:0]      C_MAXCP = 21'h10FFFF;
    localparam logic [CW-1:0]    C_DEPTH = CW'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONT = 1'b1
    } state_t;

    // Decoder state
    state_t        r_state;
    logic [1:0]    r_rem;
    logic [20:0]   r_acc;
    logic [2:0]    r_len;
    logic [2:0]    r_tot;
    logic [7:0]    r_pend;
    logic          r_pend_v;

    // FIFO storage: {err, len[2:0], cp[20:0]}
    logic [24:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Next-state and push signals from the byte decoder
    state_t        w_nstate;
    logic [1:0]    w_nrem;
    logic [20:0]   w_nacc;
    logic [2:0]    w_nlen;
    logic [2:0]    w_ntot;
    logic          w_set_pend;
    logic          w_push;
    logic [20:0]   w_pcp;
    logic          w_perr;
    logic [2:0]    w_plen;
    logic [20:0]   w_shift;
    logic [20:0]   w_min;
    logic          w_bad;

    logic          w_full;
    logic          w_fire;
    logic [7:0]    w_byte;
    logic          w_pop;
    logic          w_push_en;
    logic [24:0]   w_head;

    assign w_full    = (r_count == C_DEPTH);
    assign in_ready  = !w_full && !r_pend_v;
    // A held byte replays ahead of new input and only waits for FIFO space
    assign w_fire    = r_pend_v ? !w_full : (in_valid && in_ready);
    assign w_byte    = r_pend_v ? r_pend : in_byte;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_push_en = w_fire && w_push;
    assign busy      = (r_state != ST_IDLE) || r_pend_v;
    assign fifo_count = r_count;

    assign w_head  = r_mem[r_rd_ptr];
    assign out_cp  = w_head[20:0];
    assign out_len = w_head[23:21];
    assign out_err = w_head[24];

    // Accumulator after folding in a continuation byte, and its validity limits
    assign w_shift = {r_acc[14:0], w_byte[5:0]};
    always_comb begin
        case (r_tot)
            3'd2:    w_min = 21'h000080;
            3'd3:    w_min = 21'h000800;
            default: w_min = 21'h010000;
        endcase
    end
    assign w_bad = (STRICT != 0) &&
                   ((w_shift < w_min) || (w_shift[20:11] == 10'h01B) || (w_shift > C_MAXCP));

    // Byte decoder: next sequence state and the FIFO entry this byte produces
    always_comb begin
        w_nstate   = r_state;
        w_nrem     = r_rem;
        w_nacc     = r_acc;
        w_nlen     = r_len;
        w_ntot     = r_tot;
        w_set_pend = 1'b0;
        w_push     = 1'b0;
        w_pcp      = '0;
        w_perr     = 1'b0;
        w_plen     = '0;
        if (r_state == ST_IDLE) begin
            if (!w_byte[7]) begin
                w_push = 1'b1;
                w_pcp  = {13'b0, w_byte};
                w_plen = 3'd1;
            end else if (w_byte[7:5] == 3'b110) begin
                w_nacc   = {16'b0, w_byte[4:0]};
                w_nrem   = 2'd1;
                w_nlen   = 3'd1;
                w_ntot   = 3'd2;
                w_nstate = ST_CONT;
            end else if (w_byte[7:4] == 4'b1110) begin
                w_nacc   = {17'b0, w_byte[3:0]};
                w_nrem   = 2'd2;
                w_nlen   = 3'd1;
                w_ntot   = 3'd3;
                w_nstate = ST_CONT;
            end else if (w_byte[7:3] == 5'b11110) begin
                w_nacc   = {18'b0, w_byte[2:0]};
                w_nrem   = 2'd3;
                w_nlen   = 3'd1;
                w_ntot   = 3'd4;
                w_nstate = ST_CONT;
            end else begin
                // Stray continuation or F8-FF lead: nothing accumulated yet
                w_push = 1'b1;
                w_perr = 1'b1;
                w_pcp  = (REPLACE != 0) ? C_REPL : 21'h0;
                w_plen = 3'd1;
            end
        end else begin
            if (w_byte[7:6] == 2'b10) begin
                w_nacc = w_shift;
                w_nlen = r_len + 3'd1;
                w_nrem = r_rem - 2'd1;
                if (r_rem == 2'd1) begin
                    w_push   = 1'b1;
                    w_perr   = w_bad;
                    w_pcp    = (w_bad && (REPLACE != 0)) ? C_REPL : w_shift;
                    w_plen   = r_tot;
                    w_nstate = ST_IDLE;
                end
            end else begin
                // Truncated sequence: report it, then replay the interrupting byte
                w_push     = 1'b1;
                w_perr     = 1'b1;
                w_pcp      = (REPLACE != 0) ? C_REPL : r_acc;
                w_plen     = r_len;
                w_set_pend = 1'b1;
                w_nstate   = ST_IDLE;
            end
        end
    end

    // Sequence FSM and pending-byte register; frozen whenever no byte fires
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_acc    <= '0;
            r_len    <= '0;
            r_tot    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
        end else if (w_fire) begin
            r_state  <= w_nstate;
            r_rem    <= w_nrem;
            r_acc    <= w_nacc;
            r_len    <= w_nlen;
            r_tot    <= w_ntot;
            r_pend_v <= w_set_pend;
            if (w_set_pend) begin
                r_pend <= w_byte;
            end
        end
    end

    // Output FIFO: storage is cleared on reset so the head is never X
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_en) begin
                r_mem[r_wr_ptr] <= {w_perr, w_plen, w_pcp};
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
